// File: rtl/lane_splitter_if.sv
// Handshake bundle for lane_splitter: one 2*DATA_WIDTH input stream and two DATA_WIDTH output lanes.
// The master modport is the environment side (producer and consumers); slave is the splitter.
interface lane_splitter_if #(
    parameter int DATA_WIDTH = 8
);
    logic [2*DATA_WIDTH-1:0] din_data;
    logic                    din_vld;
    logic                    din_rd;

    logic [DATA_WIDTH-1:0]   dout0_data;
    logic                    dout0_vld;
    logic                    dout0_rd;

    logic [DATA_WIDTH-1:0]   dout1_data;
    logic                    dout1_vld;
    logic                    dout1_rd;

    // valid/ready: a transfer happens on every rising edge where vld && rd;
    // the sender holds data stable while vld && !rd, and rd never depends on vld.
    modport master (
        output din_data, din_vld, dout0_rd, dout1_rd,
        input  din_rd, dout0_data, dout0_vld, dout1_data, dout1_vld
    );

    modport slave (
        input  din_data, din_vld, dout0_rd, dout1_rd,
        output din_rd, dout0_data, dout0_vld, dout1_data, dout1_vld
    );
endinterface

// File: rtl/lane_splitter.sv
// Splits each 2*DATA_WIDTH input word into two lanes, each with a 2-entry register FIFO.
// Optional accepted-word counter on words_cnt is built only when LANE_SPLITTER_STATS_EN is defined.
module lane_splitter #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    lane_splitter_if.slave       bus,
    output logic [15:0]          words_cnt
);
    localparam int LANES = 2;

    logic [DATA_WIDTH-1:0] head_q [LANES];
    logic [DATA_WIDTH-1:0] tail_q [LANES];
    logic [1:0]            cnt_q  [LANES];
    logic [DATA_WIDTH-1:0] head_d [LANES];
    logic [DATA_WIDTH-1:0] tail_d [LANES];
    logic [1:0]            cnt_d  [LANES];

    logic             accept;
    logic [LANES-1:0] pop;
    logic [LANES-1:0] lane_rd;
    logic             in_rd;

    // Ready looks only at registered counts, so no consumer ready reaches din_rd.
    assign in_rd      = !rst && (cnt_q[0] != 2'd2) && (cnt_q[1] != 2'd2);
    assign bus.din_rd = in_rd;
    assign accept     = bus.din_vld && in_rd;

    assign lane_rd[0] = bus.dout0_rd;
    assign lane_rd[1] = bus.dout1_rd;

    always_comb begin
        for (int k = 0; k < LANES; k++) begin
            pop[k] = (cnt_q[k] != 2'd0) && lane_rd[k];
        end
    end

    always_comb begin
        for (int k = 0; k < LANES; k++) begin
            head_d[k] = head_q[k];
            tail_d[k] = tail_q[k];
            cnt_d[k]  = cnt_q[k];
            unique case ({accept, pop[k]})
                2'b10: begin
                    if (cnt_q[k] == 2'd0) begin
                        head_d[k] = bus.din_data[k*DATA_WIDTH +: DATA_WIDTH];
                        cnt_d[k]  = 2'd1;
                    end else begin
                        tail_d[k] = bus.din_data[k*DATA_WIDTH +: DATA_WIDTH];
                        cnt_d[k]  = 2'd2;
                    end
                end
                2'b01: begin
                    if (cnt_q[k] == 2'd2) begin
                        head_d[k] = tail_q[k];
                        cnt_d[k]  = 2'd1;
                    end else begin
                        cnt_d[k]  = 2'd0;
                    end
                end
                // Push with pop is only possible at count 1: full blocks push, empty blocks pop.
                2'b11: begin
                    head_d[k] = bus.din_data[k*DATA_WIDTH +: DATA_WIDTH];
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < LANES; k++) begin
                head_q[k] <= '0;
                tail_q[k] <= '0;
                cnt_q[k]  <= 2'd0;
            end
        end else begin
            for (int k = 0; k < LANES; k++) begin
                head_q[k] <= head_d[k];
                tail_q[k] <= tail_d[k];
                cnt_q[k]  <= cnt_d[k];
            end
        end
    end

    assign bus.dout0_data = head_q[0];
    assign bus.dout0_vld  = (cnt_q[0] != 2'd0);
    assign bus.dout1_data = head_q[1];
    assign bus.dout1_vld  = (cnt_q[1] != 2'd0);

`ifdef LANE_SPLITTER_STATS_EN
    logic [15:0] words_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            words_q <= 16'd0;
        end else if (accept) begin
            words_q <= words_q + 16'd1;
        end
    end

    assign words_cnt = words_q;
`else
    assign words_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_lane_splitter.sv
// Directed bench for lane_splitter: reset, streaming, backpressure, full-lane stall, mid-run reset, word counter.
module tb_lane_splitter;
    logic        clk;
    logic        rst;
    logic [15:0] words_cnt;
    int          n_tests;
    int          n_fail;
    int          acc;

    lane_splitter_if #(.DATA_WIDTH(8)) bus ();

    lane_splitter #(.DATA_WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .words_cnt (words_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout: observed no end expected end by 2ms");
        $fatal(1, "bench timeout");
    end

    function automatic logic [15:0] exp_wc(input int a);
`ifdef LANE_SPLITTER_STATS_EN
        logic [31:0] t;
        t = a;
        return t[15:0];
`else
        return 16'd0;
`endif
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_lanes(input string tag, input logic v0, input logic [7:0] d0,
                               input logic v1, input logic [7:0] d1);
        check({tag, "_vld0"}, {31'd0, bus.dout0_vld}, {31'd0, v0});
        if (v0) check({tag, "_dat0"}, {24'd0, bus.dout0_data}, {24'd0, d0});
        check({tag, "_vld1"}, {31'd0, bus.dout1_vld}, {31'd0, v1});
        if (v1) check({tag, "_dat1"}, {24'd0, bus.dout1_data}, {24'd0, d1});
    endtask

    task automatic check_rd(input string tag, input logic exp);
        check(tag, {31'd0, bus.din_rd}, {31'd0, exp});
    endtask

    initial begin
        int n_bulk;
        logic [15:0] w;
        n_tests = 0;
        n_fail  = 0;
        acc     = 0;

        // reset state
        rst = 1'b1;
        bus.din_data = 16'h0;
        bus.din_vld  = 1'b0;
        bus.dout0_rd = 1'b1;
        bus.dout1_rd = 1'b1;
        step();
        step();
        check_rd("rst_din_rd", 1'b0);
        check("rst_vld0", {31'd0, bus.dout0_vld}, 32'd0);
        check("rst_vld1", {31'd0, bus.dout1_vld}, 32'd0);
        check("rst_dat0", {24'd0, bus.dout0_data}, 32'd0);
        check("rst_dat1", {24'd0, bus.dout1_data}, 32'd0);
        check("rst_words", {16'd0, words_cnt}, 32'd0);
        rst = 1'b0;
        #1;
        check_rd("rel_din_rd", 1'b1);

        // back-to-back streaming
        bus.din_data = 16'h1234;
        bus.din_vld  = 1'b1;
        step();
        acc++;
        check_lanes("b2b_w0", 1'b1, 8'h34, 1'b1, 8'h12);
        bus.din_data = 16'hABCD;
        check_rd("b2b_rd0", 1'b1);
        step();
        acc++;
        check_lanes("b2b_w1", 1'b1, 8'hCD, 1'b1, 8'hAB);
        check_rd("b2b_rd1", 1'b1);
        bus.din_vld = 1'b0;
        step();
        check_lanes("b2b_empty", 1'b0, 8'h00, 1'b0, 8'h00);
        check("b2b_words", {16'd0, words_cnt}, {16'd0, exp_wc(acc)});

        // lane 1 backpressured
        bus.dout1_rd = 1'b0;
        bus.din_data = 16'h2010;
        bus.din_vld  = 1'b1;
        check_rd("bp_rd_a", 1'b1);
        step();
        acc++;
        check_lanes("bp_w1", 1'b1, 8'h10, 1'b1, 8'h20);
        bus.din_data = 16'h2111;
        check_rd("bp_rd_b", 1'b1);
        step();
        acc++;
        check_lanes("bp_w2", 1'b1, 8'h11, 1'b1, 8'h20);
        bus.din_data = 16'h2212;
        check_rd("bp_full_rd", 1'b0);
        step();
        check_lanes("bp_hold1", 1'b0, 8'h00, 1'b1, 8'h20);
        check_rd("bp_full_rd2", 1'b0);
        step();
        check_lanes("bp_hold2", 1'b0, 8'h00, 1'b1, 8'h20);
        check_rd("bp_full_rd3", 1'b0);
        // pop from the full lane while din_vld is held: no accept on this edge
        bus.dout1_rd = 1'b1;
        step();
        check_lanes("bp_pop", 1'b0, 8'h00, 1'b1, 8'h21);
        check_rd("bp_rd_open", 1'b1);
        step();
        acc++;
        check_lanes("bp_w3", 1'b1, 8'h12, 1'b1, 8'h22);
        bus.din_vld = 1'b0;
        step();
        check_lanes("bp_empty", 1'b0, 8'h00, 1'b0, 8'h00);
        check("bp_words", {16'd0, words_cnt}, {16'd0, exp_wc(acc)});

        // steady push+pop at count 1
        bus.din_data = {8'h40, 8'h80};
        bus.din_vld  = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            step();
            acc++;
            check_lanes("ss", 1'b1, 8'h80 + 8'(i - 1), 1'b1, 8'h40 + 8'(i - 1));
            check_rd("ss_rd", 1'b1);
            bus.din_data = {8'h40 + 8'(i), 8'h80 + 8'(i)};
        end
        step();
        acc++;
        check_lanes("ss_last", 1'b1, 8'h8A, 1'b1, 8'h4A);
        bus.din_vld = 1'b0;
        step();
        check_lanes("ss_empty", 1'b0, 8'h00, 1'b0, 8'h00);
        check("ss_words", {16'd0, words_cnt}, {16'd0, exp_wc(acc)});

        // fill both lanes, then reset asynchronously
        bus.dout0_rd = 1'b0;
        bus.dout1_rd = 1'b0;
        bus.din_data = 16'h5150;
        bus.din_vld  = 1'b1;
        step();
        acc++;
        bus.din_data = 16'h5352;
        step();
        acc++;
        check_lanes("full", 1'b1, 8'h50, 1'b1, 8'h51);
        check_rd("full_rd", 1'b0);
        check("full_words", {16'd0, words_cnt}, {16'd0, exp_wc(acc)});
        #2;
        rst = 1'b1;
        #1;
        acc = 0;
        check_lanes("arst", 1'b0, 8'h00, 1'b0, 8'h00);
        check_rd("arst_rd", 1'b0);
        check("arst_words", {16'd0, words_cnt}, 32'd0);
        bus.din_data = 16'h6160;
        bus.din_vld  = 1'b1;
        bus.dout0_rd = 1'b1;
        bus.dout1_rd = 1'b1;
        step();
        check_lanes("arst_hold", 1'b0, 8'h00, 1'b0, 8'h00);
        check("arst_hold_words", {16'd0, words_cnt}, 32'd0);
        rst = 1'b0;
        #1;
        check_rd("arst_rel_rd", 1'b1);
        step();
        acc++;
        check_lanes("arst_new", 1'b1, 8'h60, 1'b1, 8'h61);
        bus.din_vld = 1'b0;
        step();
        check_lanes("arst_empty", 1'b0, 8'h00, 1'b0, 8'h00);
        check("arst_words1", {16'd0, words_cnt}, {16'd0, exp_wc(acc)});

        // bulk streaming for counter wrap
`ifdef LANE_SPLITTER_STATS_EN
        n_bulk = 65537;
`else
        n_bulk = 300;
`endif
        rst = 1'b1;
        step();
        rst = 1'b0;
        acc = 0;
        bus.din_vld = 1'b1;
        for (int i = 0; i < n_bulk; i++) begin
            w = 16'(i);
            bus.din_data = w;
            step();
            acc++;
        end
        bus.din_vld = 1'b0;
        check("bulk_words", {16'd0, words_cnt}, {16'd0, exp_wc(acc)});
        w = 16'(n_bulk - 1);
        check_lanes("bulk_last", 1'b1, w[7:0], 1'b1, w[15:8]);
        check_rd("bulk_rd", 1'b1);
        step();
        check_lanes("bulk_empty", 1'b0, 8'h00, 1'b0, 8'h00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
